hazard_ctrl_mc: RTL
===================

// Module: hazard_ctrl_mc
// PURPOSE
//  Hazard unit for the 5-stage RISC-V pipeline; drives the en/clear pins of every pipeline register.
//  Generates forwarding selects, load-use stalls and branch flushes.
//  Adds a counter-based FSM that holds the Execute stage while a multi-cycle MUL/DIV op completes.
//  Sits beside the datapath; consumes register addresses and control bits from the D/E/M/W stages.
// PARAMETERS
//  MD_LAT   4   total cycles a MUL/DIV op occupies Execute; legal range 2..16
//  CNT_W    4   width of the internal latency counter; must satisfy 2**CNT_W >= MD_LAT
// PORTS
//  clk          in   1   rising-edge clock
//  reset_n      in   1   asynchronous, active-low reset
//  Rs1D,Rs2D    in   5   source registers in Decode
//  Rs1E,Rs2E    in   5   source registers in Execute
//  RdE,RdM,RdW  in   5   destination registers in Execute/Memory/Writeback
//  RegWriteM    in   1   Memory-stage instruction writes the RF
//  RegWriteW    in   1   Writeback-stage instruction writes the RF
//  LoadE        in   1   Execute-stage instruction is a load
//  PCSrcE       in   1   taken branch/jump resolved in Execute
//  MdStartE     in   1   Execute-stage instruction is a MUL/DIV op
//  ForwardAE    out  2   srcA select: 00 RF, 01 ResultW, 10 ALUResultM
//  ForwardBE    out  2   srcB select, same encoding
//  StallF,StallD,StallE  out 1   hold the PC, IF/ID and ID/EX registers (en = ~Stall)
//  FlushD,FlushE,FlushM  out 1   clear the IF/ID, ID/EX and EX/MEM registers
//  MdDoneE      out  1   pulse: MUL/DIV result is valid in Execute this cycle
// BEHAVIOUR
//  Forwarding is combinational:
//   - If Rs1E!=0 && Rs1E==RdM && RegWriteM, select 10.
//   - Else if Rs1E!=0 && Rs1E==RdW && RegWriteW, select 01.
//   - Otherwise select 00. Rs2E is handled the same way. M takes priority over W.
//  lwStall = LoadE && RdE!=0 && (Rs1D==RdE || Rs2D==RdE).
//  MUL/DIV FSM has two states, IDLE and BUSY, plus a counter cnt[CNT_W-1:0]:
//   - IDLE & MdStartE: mdStall=1; cnt<=MD_LAT-2; next state BUSY.
//   - BUSY & cnt!=0: mdStall=1; cnt<=cnt-1.
//   - BUSY & cnt==0: mdStall=0; MdDoneE=1; next state IDLE.
//   - MdStartE is ignored while BUSY. A back-to-back MUL/DIV restarts from IDLE on the cycle after MdDoneE.
//   - Result: stalls are asserted for exactly MD_LAT-1 cycles; the op leaves Execute on the MdDoneE cycle.
//  Output equations:
//   - StallF = StallD = lwStall | mdStall
//   - StallE = mdStall
//   - FlushE = (lwStall & ~mdStall) | (PCSrcE & ~mdStall)
//   - FlushD = PCSrcE & ~mdStall
//   - FlushM = mdStall (inserts bubbles behind the held op)
//  Simultaneous events:
//   - lwStall with PCSrcE: the flush wins; FlushD=FlushE=1 and StallF=StallD=1 (the new PC loads next cycle after the stall drops).
//   - lwStall and MdStartE cannot both hold, because LoadE excludes a MUL/DIV.
//  Reset: the FSM goes to IDLE and cnt to 0 immediately, including in the middle of an op.
//   All stall/flush outputs and MdDoneE are 0 during reset; forwarding stays combinational.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined:
//   - Adds output ports StallCnt[31:0] (cycles with StallF=1) and FlushCnt[31:0] (cycles with FlushE=1).
//   - Both counters wrap modulo 2**32 and reset to 0.
//  Not defined: the ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  riscv_pkg holds:
//   - the FWD_RF/FWD_W/FWD_M 2-bit encodings
//   - the md_state_t enum {MD_IDLE, MD_BUSY}
//   - the REG_ZERO constant
//  One sub-module, md_stall_fsm (FSM + cnt; outputs mdStall, MdDoneE).
//   Forwarding and lwStall logic stay at the top level.
// TESTING
//  1. RdM=5, RegWriteM=1, Rs1E=5; RdW=5, RegWriteW=1 -> ForwardAE=10. Rs1E=0 -> ForwardAE=00.
//  2. LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle; next cycle ForwardBE=01.
//  3. PCSrcE=1 in IDLE -> FlushD=FlushE=1, no stalls.
//  4. MD_LAT=4, MdStartE held -> StallE=FlushM=1 for exactly 3 cycles, MdDoneE on cycle 4, then IDLE.
//   Back-to-back MdStartE -> second op also sees 3 stalls.
//  5. Assert reset_n=0 on the second BUSY cycle -> outputs 0 immediately.
//   After release with MdStartE=1 -> full 3-cycle stall restarts.
//  6. HAZ_PERF_CNT_EN with scenarios 2+4 -> StallCnt=4, FlushCnt=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings and types for the pipeline hazard unit.
package riscv_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_t;

  // Memory stage wins over Writeback; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic wr_m, input logic [4:0] rd_w,
                                         input logic wr_w);
    if (rs != REG_ZERO && rs == rd_m && wr_m) begin
      return FWD_M;
    end else if (rs != REG_ZERO && rs == rd_w && wr_w) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/md_stall_fsm.sv
// Holds Execute for a multi-cycle MUL/DIV op: MD_LAT-1 stall cycles, then a MdDoneE pulse.
module md_stall_fsm
  import riscv_pkg::*;
#(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic MdStartE,
  output logic mdStall,
  output logic MdDoneE
);

  localparam logic [CNT_W-1:0] CntInit = CNT_W'(MD_LAT - 2);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mdStall = 1'b0;
    MdDoneE = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (MdStartE) begin
          mdStall = 1'b1;
          cnt_d   = CntInit;
          state_d = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (cnt_q != '0) begin
          mdStall = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          MdDoneE = 1'b1;
          state_d = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
    // The IDLE start term is combinational, so mask it while reset is held.
    if (!reset_n) begin
      mdStall = 1'b0;
      MdDoneE = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard unit: forwarding, load-use stall, branch flush and MUL/DIV hold.
// Optional HAZ_PERF_CNT_EN adds StallCnt/FlushCnt performance counters.
module hazard_ctrl_mc
  import riscv_pkg::*;
#(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        LoadE,
  input  logic        PCSrcE,
  input  logic        MdStartE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        MdDoneE
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
`endif
);

  logic lw_stall;
  logic md_stall;
  logic branch_flush;

  assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
  assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

  assign lw_stall = reset_n & LoadE & (RdE != REG_ZERO) & ((Rs1D == RdE) | (Rs2D == RdE));
  assign branch_flush = reset_n & PCSrcE & ~md_stall;

  md_stall_fsm #(
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) u_md_stall_fsm (
    .clk      (clk),
    .reset_n  (reset_n),
    .MdStartE (MdStartE),
    .mdStall  (md_stall),
    .MdDoneE  (MdDoneE)
  );

  assign StallF = lw_stall | md_stall;
  assign StallD = lw_stall | md_stall;
  assign StallE = md_stall;
  assign FlushE = (lw_stall & ~md_stall) | branch_flush;
  assign FlushD = branch_flush;
  assign FlushM = md_stall;

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF) StallCnt <= StallCnt + 32'd1;
      if (FlushE) FlushCnt <= FlushCnt + 32'd1;
    end
  end
`endif

endmodule
